// File: rtl/vga_pkg.sv
// Framebuffer geometry and arbiter state encoding shared by the VGA
// framebuffer blocks.
package vga_pkg;

   localparam int FB_WIDTH  = 200;
   localparam int FB_HEIGHT = 150;
   localparam int FB_WORDS  = FB_WIDTH * FB_HEIGHT;
   localparam int PIX_W     = 12;
   localparam int ADDR_W    = 15;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } arb_state_t;

endpackage

// File: rtl/fb_clear_seq.sv
// Fill sequencer: walks the framebuffer address space with a latched colour
// and flags the final word so the arbiter can close out the fill.
module fb_clear_seq #(
   parameter int FB_WORDS = vga_pkg::FB_WORDS,
   parameter int PIX_W    = vga_pkg::PIX_W,
   parameter int ADDR_W   = vga_pkg::ADDR_W
) (
   input  logic              MAX10_CLK1_50,
   input  logic              RESET_N,
   input  logic              load,
   input  logic [PIX_W-1:0]  color_in,
   input  logic              step,
   output logic [ADDR_W-1:0] fill_addr,
   output logic [PIX_W-1:0]  fill_color,
   output logic              fill_last
);

   always_ff @(posedge MAX10_CLK1_50) begin
      if (!RESET_N) begin
         fill_addr  <= '0;
         fill_color <= '0;
      end else if (load) begin
         fill_addr  <= '0;
         fill_color <= color_in;
      end else if (step) begin
         fill_addr <= fill_addr + ADDR_W'(1);
      end
   end

   assign fill_last = (fill_addr == ADDR_W'(FB_WORDS - 1));

endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: display fetches always win, then the
// colour fill, then host writes, with one RAM access per cycle.
module fb_arbiter
   import vga_pkg::arb_state_t, vga_pkg::ST_IDLE, vga_pkg::ST_CLEAR;
#(
   parameter int FB_WORDS = vga_pkg::FB_WORDS,
   parameter int PIX_W    = vga_pkg::PIX_W,
   parameter int ADDR_W   = vga_pkg::ADDR_W
) (
   input  logic              MAX10_CLK1_50,
   input  logic              RESET_N,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic [PIX_W-1:0]  disp_data,
   output logic              disp_valid,
   input  logic              host_valid,
   output logic              host_ready,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [PIX_W-1:0]  host_data,
   output logic              host_err,
   input  logic              clear_start,
   input  logic [PIX_W-1:0]  clear_color,
   output logic              clear_busy,
   output logic              clear_done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [PIX_W-1:0]  mem_wdata,
   output logic              mem_we,
   input  logic [PIX_W-1:0]  mem_rdata,
   output arb_state_t        dbg_state
);

   arb_state_t        state;
   logic              rd_v1, rd_v2, rd_oob1, rd_oob2;
   logic              disp_oob, host_oob, host_fire;
   logic              fill_load, fill_step, fill_last;
   logic [ADDR_W-1:0] fill_addr;
   logic [PIX_W-1:0]  fill_color;

   // Host write transfers on a rising edge where host_valid && host_ready;
   // host_ready is combinational and can drop in any cycle, so host_valid
   // and its payload are held until that edge.
   assign host_ready = (state == ST_IDLE) && !disp_req && !clear_start;
   assign host_fire  = host_valid && host_ready;
   assign disp_oob   = (disp_addr >= ADDR_W'(FB_WORDS));
   assign host_oob   = (host_addr >= ADDR_W'(FB_WORDS));
   assign fill_load  = (state == ST_IDLE) && clear_start;
   assign fill_step  = (state == ST_CLEAR) && !disp_req;
   assign dbg_state  = state;

   fb_clear_seq #(
      .FB_WORDS (FB_WORDS),
      .PIX_W    (PIX_W),
      .ADDR_W   (ADDR_W)
   ) u_clear_seq (
      .MAX10_CLK1_50 (MAX10_CLK1_50),
      .RESET_N       (RESET_N),
      .load          (fill_load),
      .color_in      (clear_color),
      .step          (fill_step),
      .fill_addr     (fill_addr),
      .fill_color    (fill_color),
      .fill_last     (fill_last)
   );

   always_ff @(posedge MAX10_CLK1_50) begin
      if (!RESET_N) begin
         state      <= ST_IDLE;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_we     <= 1'b0;
         rd_v1      <= 1'b0;
         rd_v2      <= 1'b0;
         rd_oob1    <= 1'b0;
         rd_oob2    <= 1'b0;
         disp_valid <= 1'b0;
         disp_data  <= '0;
         host_err   <= 1'b0;
         clear_busy <= 1'b0;
         clear_done <= 1'b0;
      end else begin
         mem_we     <= 1'b0;
         host_err   <= 1'b0;
         clear_done <= 1'b0;

         // Two-stage fetch pipe: address out, RAM register, then capture.
         rd_v1      <= disp_req;
         rd_oob1    <= disp_req && disp_oob;
         rd_v2      <= rd_v1;
         rd_oob2    <= rd_oob1;
         disp_valid <= rd_v2;
         if (rd_v2) begin
            disp_data <= rd_oob2 ? '0 : mem_rdata;
         end

         if (disp_req) begin
            if (!disp_oob) begin
               mem_addr <= disp_addr;
            end
         end else begin
            case (state)
               ST_CLEAR: begin
                  mem_we    <= 1'b1;
                  mem_addr  <= fill_addr;
                  mem_wdata <= fill_color;
                  if (fill_last) begin
                     state      <= ST_IDLE;
                     clear_busy <= 1'b0;
                     clear_done <= 1'b1;
                  end
               end
               default: begin
                  if (host_fire) begin
                     if (host_oob) begin
                        host_err <= 1'b1;
                     end else begin
                        mem_we    <= 1'b1;
                        mem_addr  <= host_addr;
                        mem_wdata <= host_data;
                     end
                  end
               end
            endcase
         end

         if (fill_load) begin
            state      <= ST_CLEAR;
            clear_busy <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a behavioural single-port RAM and
// queue-based scoreboards for display reads and RAM writes.
module tb_fb_arbiter;
   import vga_pkg::*;

   logic              MAX10_CLK1_50 = 1'b0;
   logic              RESET_N;
   logic              disp_req;
   logic [ADDR_W-1:0] disp_addr;
   logic [PIX_W-1:0]  disp_data;
   logic              disp_valid;
   logic              host_valid;
   logic              host_ready;
   logic [ADDR_W-1:0] host_addr;
   logic [PIX_W-1:0]  host_data;
   logic              host_err;
   logic              clear_start;
   logic [PIX_W-1:0]  clear_color;
   logic              clear_busy;
   logic              clear_done;
   logic [ADDR_W-1:0] mem_addr;
   logic [PIX_W-1:0]  mem_wdata;
   logic              mem_we;
   logic [PIX_W-1:0]  mem_rdata;
   arb_state_t        dbg_state;

   logic [PIX_W-1:0]        ram [0:(1<<ADDR_W)-1];
   logic [PIX_W-1:0]        disp_exp_q[$];
   int                      disp_cyc_q[$];
   logic [ADDR_W+PIX_W-1:0] wr_exp_q[$];

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int busy_cnt = 0;
   int done_cnt = 0;
   int valid_cnt = 0;

   always #10 MAX10_CLK1_50 = ~MAX10_CLK1_50;

   fb_arbiter dut (
      .MAX10_CLK1_50 (MAX10_CLK1_50),
      .RESET_N       (RESET_N),
      .disp_req      (disp_req),
      .disp_addr     (disp_addr),
      .disp_data     (disp_data),
      .disp_valid    (disp_valid),
      .host_valid    (host_valid),
      .host_ready    (host_ready),
      .host_addr     (host_addr),
      .host_data     (host_data),
      .host_err      (host_err),
      .clear_start   (clear_start),
      .clear_color   (clear_color),
      .clear_busy    (clear_busy),
      .clear_done    (clear_done),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_we        (mem_we),
      .mem_rdata     (mem_rdata),
      .dbg_state     (dbg_state)
   );

   initial begin
      for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = '0;
   end

   always @(posedge MAX10_CLK1_50) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
      cyc <= cyc + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge MAX10_CLK1_50);
      #1;
   endtask

   task automatic push_disp(input logic [PIX_W-1:0] exp);
      disp_exp_q.push_back(exp);
      disp_cyc_q.push_back(cyc + 3);
   endtask

   task automatic push_fill(input int last, input logic [PIX_W-1:0] color);
      for (int i = 0; i <= last; i++) wr_exp_q.push_back({ADDR_W'(i), color});
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_disp_valid"}, 32'(disp_valid), 0);
      check({tag, "_disp_data"},  32'(disp_data), 0);
      check({tag, "_host_err"},   32'(host_err), 0);
      check({tag, "_clear_busy"}, 32'(clear_busy), 0);
      check({tag, "_clear_done"}, 32'(clear_done), 0);
      check({tag, "_mem_we"},     32'(mem_we), 0);
      check({tag, "_mem_addr"},   32'(mem_addr), 0);
      check({tag, "_mem_wdata"},  32'(mem_wdata), 0);
      check({tag, "_state"},      32'(dbg_state), 32'(ST_IDLE));
   endtask

   // Monitor: pops expectations whenever the DUT presents a read or a write.
   always @(negedge MAX10_CLK1_50) begin
      if (clear_busy) busy_cnt++;
      if (clear_done) done_cnt++;
      if (disp_valid) begin
         valid_cnt++;
         if (disp_exp_q.size() == 0) begin
            check("unexpected_disp_valid", 1, 0);
         end else begin
            check("disp_data", 32'(disp_data), 32'(disp_exp_q.pop_front()));
            check("disp_latency", cyc, disp_cyc_q.pop_front());
         end
      end
      if (mem_we) begin
         if (wr_exp_q.size() == 0) begin
            check("unexpected_write", 1, 0);
         end else begin
            check("mem_write", 32'({mem_addr, mem_wdata}), 32'(wr_exp_q.pop_front()));
         end
      end
   end

   initial begin
      int j;
      int nrd;
      int vmark;

      RESET_N = 1'b0;
      disp_req = 1'b0;
      disp_addr = '0;
      host_valid = 1'b0;
      host_addr = '0;
      host_data = '0;
      clear_start = 1'b0;
      clear_color = '0;

      // Reset state
      repeat (3) tick();
      @(negedge MAX10_CLK1_50);
      check_reset_outputs("reset");
      tick();
      RESET_N = 1'b1;

      // Host write RAM[5]=0xF00
      tick();
      host_valid = 1'b1; host_addr = 15'd5; host_data = 12'hF00;
      @(negedge MAX10_CLK1_50);
      check("host_ready_idle", 32'(host_ready), 1);
      wr_exp_q.push_back({15'd5, 12'hF00});
      tick();
      host_valid = 1'b0;

      // Single fetch, then back-to-back with an out-of-range address between
      tick();
      disp_req = 1'b1; disp_addr = 15'd5; push_disp(12'hF00);
      tick();
      disp_req = 1'b0;
      repeat (3) tick();
      disp_req = 1'b1; disp_addr = 15'd5; push_disp(12'hF00);
      tick();
      disp_addr = 15'd30000; push_disp(12'h000);
      tick();
      disp_addr = 15'd5; push_disp(12'hF00);
      tick();
      disp_req = 1'b0;
      repeat (3) tick();

      // Host write held off by three display cycles
      host_valid = 1'b1; host_addr = 15'd10; host_data = 12'h0A0;
      disp_req = 1'b1; disp_addr = 15'd5;
      for (int i = 0; i < 3; i++) begin
         push_disp(12'hF00);
         @(negedge MAX10_CLK1_50);
         check("host_ready_disp_block", 32'(host_ready), 0);
         tick();
      end
      disp_req = 1'b0;
      @(negedge MAX10_CLK1_50);
      check("host_ready_after_disp", 32'(host_ready), 1);
      wr_exp_q.push_back({15'd10, 12'h0A0});
      tick();
      host_valid = 1'b0;
      repeat (3) tick();
      disp_req = 1'b1; disp_addr = 15'd10; push_disp(12'h0A0);
      tick();
      disp_req = 1'b0;
      repeat (3) tick();

      // Out-of-range host write: accepted, dropped, error pulse
      host_valid = 1'b1; host_addr = 15'd30000; host_data = 12'h123;
      @(negedge MAX10_CLK1_50);
      check("host_ready_oob", 32'(host_ready), 1);
      check("host_err_before", 32'(host_err), 0);
      tick();
      host_valid = 1'b0;
      @(negedge MAX10_CLK1_50);
      check("host_err_pulse", 32'(host_err), 1);
      @(negedge MAX10_CLK1_50);
      check("host_err_clear", 32'(host_err), 0);
      tick();

      // Full fill, no display traffic; simultaneous host write loses
      busy_cnt = 0; done_cnt = 0;
      clear_start = 1'b1; clear_color = 12'h00F;
      host_valid = 1'b1; host_addr = 15'd3; host_data = 12'h777;
      push_fill(FB_WORDS - 1, 12'h00F);
      @(negedge MAX10_CLK1_50);
      check("host_ready_vs_clear", 32'(host_ready), 0);
      tick();
      clear_start = 1'b0; host_valid = 1'b0;
      check("clear_busy_start", 32'(clear_busy), 1);
      j = 0;
      while (done_cnt == 0 && j < 31000) begin
         clear_start = (j == 100);
         clear_color = 12'hFFF;
         tick();
         j++;
      end
      clear_start = 1'b0;
      check("fill1_done_seen", 32'(done_cnt > 0), 1);
      repeat (3) tick();
      check("fill1_busy_cycles", busy_cnt, FB_WORDS);
      check("fill1_done_count", done_cnt, 1);
      check("fill1_writes_left", wr_exp_q.size(), 0);
      check("fill1_state", 32'(dbg_state), 32'(ST_IDLE));

      // Fill with a display read stealing every 4th cycle
      busy_cnt = 0; done_cnt = 0;
      clear_start = 1'b1; clear_color = 12'h0F0;
      push_fill(FB_WORDS - 1, 12'h0F0);
      tick();
      clear_start = 1'b0;
      host_valid = 1'b1; host_addr = 15'd7; host_data = 12'hABC;
      j = 1; nrd = 0;
      while (clear_busy && j <= 41000) begin
         disp_req = (j % 4 == 1);
         if (disp_req) begin
            if (nrd % 2 == 0) begin
               disp_addr = 15'd29999; push_disp(12'h00F);
            end else begin
               disp_addr = 15'd0; push_disp(12'h0F0);
            end
            nrd++;
         end
         @(negedge MAX10_CLK1_50);
         if (j == 2 || j == 20001 || j == 40000) check("host_ready_fill", 32'(host_ready), 0);
         tick();
         j++;
      end
      host_valid = 1'b0; disp_req = 1'b0;
      check("fill2_ended", 32'(j <= 41000), 1);
      repeat (4) tick();
      check("fill2_busy_cycles", busy_cnt, 40000);
      check("fill2_done_count", done_cnt, 1);
      check("fill2_reads", nrd, 10000);
      check("fill2_writes_left", wr_exp_q.size(), 0);

      // Reset at fill address 1000
      done_cnt = 0;
      clear_start = 1'b1; clear_color = 12'h555;
      push_fill(1000, 12'h555);
      tick();
      clear_start = 1'b0;
      j = 0;
      while (!(mem_we && mem_addr == 15'd1000) && j < 2000) begin
         tick();
         j++;
      end
      check("fill3_reached_1000", 32'(j < 2000), 1);
      RESET_N = 1'b0;
      tick();
      @(negedge MAX10_CLK1_50);
      check_reset_outputs("midfill");
      tick();
      RESET_N = 1'b1;
      @(negedge MAX10_CLK1_50);
      check("host_ready_after_reset", 32'(host_ready), 1);
      repeat (5) tick();
      check("midfill_no_done", done_cnt, 0);
      check("midfill_writes_left", wr_exp_q.size(), 0);
      disp_req = 1'b1; disp_addr = 15'd1000; push_disp(12'h555);
      tick();
      disp_addr = 15'd1001; push_disp(12'h0F0);
      tick();
      disp_req = 1'b0;
      repeat (4) tick();

      // Reset while a fetch is in flight
      vmark = valid_cnt;
      disp_req = 1'b1; disp_addr = 15'd5;
      tick();
      disp_req = 1'b0; RESET_N = 1'b0;
      tick();
      RESET_N = 1'b1;
      repeat (4) tick();
      check("inflight_valid_dropped", valid_cnt - vmark, 0);

      repeat (3) tick();
      check("disp_queue_empty", disp_exp_q.size(), 0);
      check("write_queue_empty", wr_exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 Parameter FB_WORDS, 30000, framebuffer depth (200x150 pixels, each shown 4x4 on 800x600).
REQ-002 Parameter PIX_W, 12, pixel width (4R:4G:4B).
REQ-003 Parameter ADDR_W, 15, framebuffer address width.
REQ-004 MAX10_CLK1_50  in  1  sole clock; all logic on posedge.
REQ-005 RESET_N  in  1  synchronous, active-low reset.
REQ-006 disp_req  in  1  display fetch request, single-cycle pulse.
REQ-007 disp_addr  in  ADDR_W  display fetch address.
REQ-008 disp_data  out  PIX_W  fetched pixel.
REQ-009 disp_valid  out  1  one-cycle pulse; disp_data valid.
REQ-010 host_valid  in  1  host write request.
REQ-011 host_ready  out  1  host write accepted when high with host_valid.
REQ-012 host_addr  in  ADDR_W  host write address.
REQ-013 host_data  in  PIX_W  host write pixel.
REQ-014 host_err  out  1  one-cycle pulse; out-of-range host write dropped.
REQ-015 clear_start  in  1  start fill pulse.
REQ-016 clear_color  in  PIX_W  fill pixel, sampled on accepted clear_start.
REQ-017 clear_busy  out  1  high while fill in progress.
REQ-018 clear_done  out  1  one-cycle pulse at fill completion.
REQ-019 mem_addr / mem_wdata / mem_we  out  ADDR_W / PIX_W / 1  registered single-port RAM port.
REQ-020 mem_rdata  in  PIX_W  RAM read data, valid one cycle after mem_addr edge.

Function
REQ-021 States: IDLE, CLEAR; only one RAM access per cycle.
REQ-022 Priority per cycle: display > fill (CLEAR) > host (IDLE only).
REQ-023 Display accepted every cycle disp_req=1; never stalled, no ready signal.
REQ-024 Display latency: disp_req at edge k -> mem_addr at edge k, RAM samples at k+1, disp_data/disp_valid registered at edge k+2; back-to-back requests produce back-to-back valids in order.
REQ-025 disp_addr >= FB_WORDS: no RAM read (mem_we=0), disp_valid still pulses at k+2 with disp_data=0.
REQ-026 host_ready = (state==IDLE) && !disp_req && !clear_start, combinational.
REQ-027 Host handshake at edge with host_valid && host_ready: mem_we=1, mem_addr=host_addr, mem_wdata=host_data for one cycle.
REQ-028 host_addr >= FB_WORDS: accepted (ready high), no write, host_err pulses the next cycle.
REQ-029 clear_start in IDLE: latch clear_color, fill counter=0, enter CLEAR, clear_busy=1 the next cycle.
REQ-030 clear_start in CLEAR ignored; clear_start same cycle as host_valid wins (host not accepted).
REQ-031 CLEAR: each cycle without disp_req writes clear_color at counter, counter+1; cycles with disp_req pause the fill.
REQ-032 Write to FB_WORDS-1 ends fill: next edge state=IDLE, clear_busy=0, clear_done=1 for one cycle.
REQ-033 Fill duration = FB_WORDS + number of display-stolen cycles.
REQ-034 mem_we=0 in every cycle with no write; mem_addr/mem_wdata hold last value.

Reset
REQ-035 RESET_N=0 at an edge: state=IDLE; all outputs 0; counter=0; pipeline valids cleared.
REQ-036 Reset mid-fill aborts the fill, no clear_done; partially filled RAM contents untouched.
REQ-037 Reset mid-fetch drops the in-flight disp_valid.

Structure
REQ-038 FB_WORDS, PIX_W, ADDR_W, FB_WIDTH=200, FB_HEIGHT=150, state encoding in shared package vga_pkg.
REQ-039 One sub-module fb_clear_seq (counter, color latch, done detect); arbitration and fetch pipeline in fb_arbiter.

Verification
REQ-040 disp_req at addr 5 with RAM[5]=0xF00 -> disp_valid and disp_data=0xF00 exactly 2 cycles later.
REQ-041 host_valid addr 10 data 0x0A0 with disp_req high 3 cycles -> host_ready low 3 cycles, single write on 4th, mem_we=1 once.
REQ-042 host write addr 30000 -> host_ready=1, no mem_we, host_err pulse next cycle.
REQ-043 clear_start color 0x00F, no display traffic -> 30000 writes addr 0..29999, clear_done once, clear_busy 30000 cycles.
REQ-044 Same fill with disp_req every 4th cycle -> display data correct, fill completes after 40000 cycles, host_ready low throughout.
REQ-045 RESET_N low at fill addr 1000 -> outputs 0, no clear_done, host_ready high the cycle after release.
